vram_writer: RTL
================

Name: vram_writer

Overview:
- Write-side companion to the video controller's VRAM fetch port.
- Snoops Z80 memory writes and keeps only those that land in screen RAM (bank 5 or bank 7, 16 KB each).
- Queues the kept writes in a small FIFO and replays them into the dual-page video RAM.
- Replays happen only in 7 MHz slots where the video reader is not fetching, so pixel/attribute reads are never disturbed.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
AW, 15, VRAM address width (bit 14 = bank select 5/7, bits 13:0 = offset)

Ports:
clk_sys  in  1  master clock
reset_n  in  1  asynchronous active-low reset
ce_7mp  in  1  7 MHz pixel-rate clock enable (positive phase)
addr  in  16  CPU address bus
din  in  8  CPU data out (write data)
nMREQ  in  1  CPU memory request, active low
nWR  in  1  CPU write strobe, active low
nRFSH  in  1  CPU refresh, active low
m128  in  1  128K memory map enabled
page_ram  in  3  bank currently mapped at C000-FFFF
rd_busy  in  1  video reader owns the VRAM port this ce_7mp slot
ovf_clr  in  1  clears sticky overflow flag
vram_we  out  1  one-clk_sys write pulse to VRAM
vram_waddr  out  AW  VRAM write address
vram_wdata  out  8  VRAM write data
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a screen write was dropped

Behaviour:
- Reset (async, reset_n=0): vram_we=0, vram_waddr=0, vram_wdata=0, level=0, overflow=0, FSM=IDLE, strobe history=inactive. Applies immediately, including mid-write; a pulse in flight is cut and its entry is lost.
- Write detect: wr_act = ~nMREQ & ~nWR & nRFSH, registered each clk_sys. Exactly one capture per CPU write, on the clk_sys edge where wr_act goes 0->1. A held strobe does not recapture.
- Address decode at capture time:
  - addr[15:14]=01 -> {1'b0, addr[13:0]}.
  - addr[15:14]=11 & m128 & page_ram=5 -> {1'b0, addr[13:0]}.
  - addr[15:14]=11 & m128 & page_ram=7 -> {1'b1, addr[13:0]}.
  - Anything else is ignored.
- Coalescing: if a decoded address equals the newest undrained entry, that entry's data is overwritten in place. No push occurs and level is unchanged. Coalescing never targets an entry being popped in the same cycle.
- Push: a decoded, non-coalesced write enqueues {waddr, din}.
- Full FIFO:
  - Push with no pop in the same cycle: the write is dropped and overflow=1.
  - Push with a simultaneous pop: the push is accepted and level is unchanged.
- overflow clears on ovf_clr=1. If ovf_clr and a new drop occur in the same cycle, the drop wins (overflow stays 1).
- FSM:
  - IDLE: level=0. Moves to ARM when level becomes nonzero.
  - ARM: waits for ce_7mp=1 & rd_busy=0 sampled on the same edge. On that edge it loads vram_waddr/vram_wdata from the head entry, sets vram_we=1, pops, and moves to WRITE.
  - WRITE: exactly one clk_sys cycle, then vram_we=0. Moves to ARM if level>0, else IDLE.
- Latency: an isolated write captured on edge N with an idle FIFO produces vram_we on the first qualifying ce_7mp edge after N. That is at least N+1, and never the same edge as the capture.
- Throughput: at most one VRAM write per ce_7mp slot.
- Ordering: drain order equals capture order. Coalesced data replaces in place and keeps its position.
- vram_waddr/vram_wdata hold their last values while vram_we=0.

Decomposition:
- Shared package video_pkg:
  - bank-select constants BANK_SCR0=3'd5, BANK_SCR1=3'd7.
  - enum vw_state_t {IDLE, ARM, WRITE}.
  - struct vw_entry_t {logic [AW-1:0] a; logic [7:0] d;}.
- One sub-module, scr_wr_fifo: a DEPTH-entry circular buffer with push, pop, head, tail-entry compare and in-place tail rewrite, plus level. The decode logic and FSM live in vram_writer.

Test Plan:
- Reset: reset_n low mid-WRITE -> vram_we=0 asynchronously; level=0, overflow=0; no further pulses after release.
- Basic write: page_ram=0, write 0x4123<-0xA5, rd_busy=0 -> single vram_we with waddr=0x0123, wdata=0xA5; level returns to 0.
- Paging:
  - m128=1, page_ram=7, write 0xC010<-0x3C -> waddr=0x4010.
  - page_ram=5, write 0xC010 -> waddr=0x0010.
  - page_ram=3, write 0xC010 -> no vram_we.
  - m128=0, write 0xC010 -> no vram_we.
  - write 0x8000 -> no vram_we.
- Slot gating: rd_busy=1 for 10 ce_7mp slots with 2 writes queued -> no vram_we during those slots; after release, pulses on two consecutive slots in capture order.
- Coalescing: rd_busy=1, write 0x5800<-0x11 then 0x5800<-0x22 -> level=1; after release, one pulse with wdata=0x22.
- Overflow: DEPTH=4, rd_busy=1, 5 distinct writes -> level=4, overflow=1, and the 5th write is never emitted. Pulse ovf_clr -> overflow=0. Simultaneous push+pop at full -> no overflow.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Package     : video_pkg
// Description : Shared types and constants for the screen-RAM write path.
//               Bank numbers of the two screen pages, the writer FSM state
//               encoding and the layout of one queued write.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // 128K banks that hold a displayable screen
  localparam logic [2:0] BANK_SCR0 = 3'd5;
  localparam logic [2:0] BANK_SCR1 = 3'd7;

  // Default VRAM address width: bit 14 selects bank 5/7, bits 13:0 offset
  localparam int VW_AW = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WRITE = 2'd2
  } vw_state_t;

  typedef struct packed {
    logic [VW_AW-1:0] a;
    logic [7:0]       d;
  } vw_entry_t;

endpackage
`default_nettype wire

// File: rtl/scr_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scr_wr_fifo
// Description : Small circular buffer of pending screen writes. Besides the
//               usual push/pop it exposes the address of the newest entry and
//               can rewrite that entry's data in place, so repeated writes to
//               one location collapse into a single queued write.
// Ports       : clk, rst_n          clock, async active-low reset
//               push/push_a/push_d  enqueue one {address, data}
//               pop                 drop the head entry
//               rewrite/rewrite_d   replace data of the newest entry
//               head_a/head_d       oldest entry
//               tail_a              address of the newest entry
//               level/full/empty    occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module scr_wr_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = VW_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [AW-1:0]          push_a,
  input  logic [7:0]             push_d,
  input  logic                   pop,
  input  logic                   rewrite,
  input  logic [7:0]             rewrite_d,
  output logic [AW-1:0]          head_a,
  output logic [7:0]             head_d,
  output logic [AW-1:0]          tail_a,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [AW-1:0] mem_a [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  // Pointers are PW bits wide, so they wrap at DEPTH on their own.
  assign tail_ptr = wr_ptr - PW'(1);

  assign do_pop   = pop & ~empty;
  // A push into a full buffer is legal only when the head leaves this cycle.
  assign do_push  = push & (~full | do_pop);

  assign head_a   = mem_a[rd_ptr];
  assign head_d   = mem_d[rd_ptr];
  assign tail_a   = mem_a[tail_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_a[wr_ptr] <= push_a;
      mem_d[wr_ptr] <= push_d;
    end
    if (rewrite) begin
      mem_d[tail_ptr] <= rewrite_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_writer.sv
`default_nettype none
// ============================================================================
// Module      : vram_writer
// Description : Snoops Z80 memory writes, keeps those that land in screen RAM
//               (bank 5 or bank 7), queues them and replays them into the
//               dual-page VRAM during 7 MHz slots the video reader leaves free.
// Ports       : clk_sys, reset_n    master clock, async active-low reset
//               ce_7mp              7 MHz slot enable
//               addr, din           CPU address / write data
//               nMREQ, nWR, nRFSH   CPU bus strobes (active low)
//               m128, page_ram      128K paging state (bank at C000-FFFF)
//               rd_busy             video reader owns VRAM this slot
//               ovf_clr             clears the sticky overflow flag
//               vram_we/waddr/wdata one-cycle VRAM write
//               level               queue occupancy
//               overflow            sticky: a screen write was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module vram_writer
  import video_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = VW_AW
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce_7mp,
  input  logic [15:0]            addr,
  input  logic [7:0]             din,
  input  logic                   nMREQ,
  input  logic                   nWR,
  input  logic                   nRFSH,
  input  logic                   m128,
  input  logic [2:0]             page_ram,
  input  logic                   rd_busy,
  input  logic                   ovf_clr,
  output logic                   vram_we,
  output logic [AW-1:0]          vram_waddr,
  output logic [7:0]             vram_wdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int LW = $clog2(DEPTH) + 1;

  vw_state_t     state;
  vw_state_t     state_nx;

  logic          wr_act;
  logic          wr_act_q;
  logic          capture;
  logic          dec_hit;
  logic [AW-1:0] dec_a;

  logic          fire;
  logic          coalesce;
  logic          push_req;
  logic          push;
  logic          drop;

  logic [AW-1:0] head_a;
  logic [7:0]    head_d;
  logic [AW-1:0] tail_a;
  logic          full;
  logic          empty;

  // --------------------------------------------------------------------------
  // Write detection: one capture on the rising edge of the combined strobe;
  // refresh cycles never count.
  // --------------------------------------------------------------------------
  assign wr_act  = ~nMREQ & ~nWR & nRFSH;
  assign capture = wr_act & ~wr_act_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) wr_act_q <= 1'b0;
    else          wr_act_q <= wr_act;
  end

  // --------------------------------------------------------------------------
  // Screen-RAM decode. 4000-7FFF is always bank 5; C000-FFFF only when the
  // 128K map is on and bank 5 or 7 is paged in.
  // --------------------------------------------------------------------------
  always_comb begin
    dec_hit = 1'b0;
    dec_a   = '0;
    if (addr[15:14] == 2'b01) begin
      dec_hit = 1'b1;
      dec_a   = AW'({1'b0, addr[13:0]});
    end else if (addr[15:14] == 2'b11 && m128) begin
      if (page_ram == BANK_SCR0) begin
        dec_hit = 1'b1;
        dec_a   = AW'({1'b0, addr[13:0]});
      end else if (page_ram == BANK_SCR1) begin
        dec_hit = 1'b1;
        dec_a   = AW'({1'b1, addr[13:0]});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Queue control
  // --------------------------------------------------------------------------
  assign fire     = (state == ARM) & ce_7mp & ~rd_busy & ~empty;

  // Merge into the newest entry unless that entry is the head leaving now,
  // in which case the write must be queued behind it instead.
  assign coalesce = capture & dec_hit & ~empty & (tail_a == dec_a)
                  & ~(fire & (level == LW'(1)));
  assign push_req = capture & dec_hit & ~coalesce;
  assign push     = push_req & (~full | fire);
  assign drop     = push_req & full & ~fire;

  scr_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .push      (push),
    .push_a    (dec_a),
    .push_d    (din),
    .pop       (fire),
    .rewrite   (coalesce),
    .rewrite_d (din),
    .head_a    (head_a),
    .head_d    (head_d),
    .tail_a    (tail_a),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // --------------------------------------------------------------------------
  // Replay FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      // Leave IDLE on the capture edge itself so the very next slot can fire.
      IDLE:    if (push) state_nx = ARM;
      ARM:     if (fire) state_nx = WRITE;
      WRITE:   state_nx = (!empty || push) ? ARM : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // VRAM write port and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      overflow   <= 1'b0;
    end else begin
      vram_we <= fire;
      if (fire) begin
        vram_waddr <= head_a;
        vram_wdata <= head_d;
      end
      // A new drop outranks a clear in the same cycle.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire
